prefix_adder_pipe: RTL and testbench
====================================

// Module: prefix_adder_pipe
// PURPOSE
//  Parametrised Kogge-Stone add/subtract unit. Stage 0 forms per-bit generate
//  (A&B) and propagate (A^B); clog2(WIDTH) prefix levels combine them; the sum
//  stage XORs propagate with the carries. PIPE_DEPTH register stages sit between
//  levels, with valid/ready flow control. Used as the ALU adder in execute.
// PARAMETERS
//  WIDTH       `LEN_DATA  operand width, >=2; need not be a power of two
//  PIPE_DEPTH  2          register stages, 1..clog2(WIDTH)+1; registers evenly spaced over levels
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit accepts a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      1: A-B (B inverted, carry-in forced 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): every stage valid bit cleared; out_valid=0;
//    sum/cout/ovf/zero=0. Datapath registers are also reset to 0.
//  - Transfer: input on in_valid&in_ready; output on out_valid&out_ready.
//  - Stage k advances when its successor is empty or advancing in the same
//    cycle (bubble-collapsing); last stage advances on out_ready.
//    in_ready = !valid[0] | adv[0]; no combinational path from in_valid to in_ready.
//  - Latency: PIPE_DEPTH cycles from accept to out_valid with no stalls.
//    Throughput one result per cycle while out_ready=1.
//  - Stall: out_valid=1 & out_ready=0 holds sum/cout/ovf/zero stable; upstream
//    stages fill, then in_ready drops. Maximum occupancy = PIPE_DEPTH beats.
//  - Simultaneous accept and emit on a full pipe: allowed, occupancy unchanged.
//  - Operand width rule: B' = sub ? ~b : b; c0 = sub ? 1 : cin; sum = a+B'+c0
//    mod 2^WIDTH; cout = bit WIDTH of the (WIDTH+1)-bit sum.
//  - Prefix level j (0-based) combines bit i with bit i-2^j; bits i<2^j pass.
//    c0 is folded in as generate of a virtual bit -1.
//  - Reset mid-operation: in-flight beats dropped, no partial result emitted;
//    first beat after rst_n release behaves as if pipe were empty.
//  - Flags travel with their beat; no state shared across beats.
// CONFIGURATION
//  ADDER_SAT_EN defined: signed saturation. When ovf=1, sum is clamped to
//   0x7F..F if a[MSB]=0, else 0x80..0 (for sub, compare with a and ~b); ovf
//   still reports 1; zero computed on the clamped sum; cout unchanged.
//   Adds no latency.
//  ADDER_SAT_EN undefined: sum always wraps mod 2^WIDTH; no clamp logic
//   synthesised.
// TESTING (WIDTH=32, PIPE_DEPTH=2 unless noted)
//  1 a=0x0000_0001 b=0xFFFF_FFFF cin=0 sub=0 -> after 2 cycles sum=0, cout=1,
//    zero=1, ovf=0.
//  2 a=0x7FFF_FFFF b=0x0000_0001 sub=0 -> sum=0x8000_0000, ovf=1, cout=0; with
//    ADDER_SAT_EN sum=0x7FFF_FFFF, ovf=1.
//  3 a=5 b=7 sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0; a=7 b=5 sub=1 -> sum=2, cout=1.
//  4 Back-to-back 100 random beats, out_ready random 50% -> results in order,
//    match golden model, in_ready low only while 2 beats held.
//  5 Stream 3 beats, assert rst_n=0 in cycle 2 for 1 cycle -> out_valid stays 0,
//    next accepted beat emerges exactly 2 cycles after accept.
//  6 WIDTH=13 PIPE_DEPTH=5, exhaustive cin/sub sweep on 2000 random pairs ->
//    sum/cout/ovf/zero match model; latency 5.

Source files
------------

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract unit with valid/ready flow control.
// Optional signed saturation is enabled by defining ADDER_SAT_EN.
`ifndef LEN_DATA
`define LEN_DATA 32
`endif

module prefix_adder_pipe #(
    parameter int WIDTH      = `LEN_DATA,
    parameter int PIPE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int STEPS  = LEVELS + 1;

    // Prefix entry 0 is the virtual bit -1 carrying c0; entry i is operand bit i-1,
    // so after the last level g[i] is the carry into bit i.
    typedef struct packed {
        logic             a_msb;
        logic             g_msb;
        logic [WIDTH-1:0] p_bit;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
    } gp_t;

    // Register k (of PIPE_DEPTH-1 intermediate ones) sits after work step
    // ((k+1)*STEPS)/PIPE_DEPTH - 1; the last register always follows the sum stage.
    function automatic int reg_stage(input int step);
        int r;
        r = -1;
        for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
            if (((k + 1) * STEPS) / PIPE_DEPTH - 1 == step) r = k;
        end
        return r;
    endfunction

    function automatic gp_t make_gp(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                                    input logic c_in, input logic do_sub);
        gp_t              r;
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH-1:0] gen;
        logic [WIDTH-1:0] prop;
        b_eff   = do_sub ? ~op_b : op_b;
        gen     = op_a & b_eff;
        prop    = op_a ^ b_eff;
        r.g     = {gen[WIDTH-2:0], (do_sub | c_in)};
        r.p     = {prop[WIDTH-2:0], 1'b0};
        r.p_bit = prop;
        r.g_msb = gen[WIDTH-1];
        r.a_msb = op_a[WIDTH-1];
        return r;
    endfunction

    function automatic gp_t prefix_level(input gp_t d, input int span);
        gp_t r;
        r = d;
        for (int i = span; i < WIDTH; i++) begin
            r.g[i] = d.g[i] | (d.p[i] & d.g[i-span]);
            r.p[i] = d.p[i] & d.p[i-span];
        end
        return r;
    endfunction

    gp_t x [0:LEVELS];
    gp_t y [0:LEVELS];

    logic [PIPE_DEPTH-1:0] v;
    logic [PIPE_DEPTH-1:0] en;
    logic [PIPE_DEPTH-1:0] v_up;

    assign x[0] = make_gp(a, b, cin, sub);

    for (genvar s = 0; s < LEVELS; s++) begin : g_step
        localparam int K = reg_stage(s);
        if (K >= 0) begin : g_reg
            gp_t r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r <= '0;
                end else if (en[K]) begin
                    r <= x[s];
                end
            end
            assign y[s] = r;
        end else begin : g_wire
            assign y[s] = x[s];
        end
        assign x[s+1] = prefix_level(y[s], 1 << s);
    end

    assign y[LEVELS] = x[LEVELS];

    // Bubble-collapsing enables: a stage loads when empty or when its successor loads.
    always_comb begin
        en = '0;
        en[PIPE_DEPTH-1] = !v[PIPE_DEPTH-1] | out_ready;
        for (int k = PIPE_DEPTH - 2; k >= 0; k--) begin
            en[k] = !v[k] | en[k+1];
        end
    end

    if (PIPE_DEPTH == 1) begin : g_vup1
        assign v_up = in_valid;
    end else begin : g_vupn
        assign v_up = {v[PIPE_DEPTH-2:0], in_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            v <= (en & v_up) | (~en & v);
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v[PIPE_DEPTH-1];

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_fin;
    logic             cout_nxt;
    logic             ovf_nxt;

    always_comb begin
        carry    = y[LEVELS].g;
        sum_raw  = y[LEVELS].p_bit ^ carry;
        cout_nxt = y[LEVELS].g_msb | (y[LEVELS].p_bit[WIDTH-1] & carry[WIDTH-1]);
        ovf_nxt  = carry[WIDTH-1] ^ cout_nxt;
`ifdef ADDER_SAT_EN
        if (ovf_nxt) begin
            sum_fin = y[LEVELS].a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_fin = sum_raw;
        end
`else
        sum_fin = sum_raw;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (en[PIPE_DEPTH-1]) begin
            sum  <= sum_fin;
            cout <= cout_nxt;
            ovf  <= ovf_nxt;
            zero <= (sum_fin == '0);
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe: 32-bit/2-stage and 13-bit/5-stage instances.
module tb_prefix_adder_pipe;

    localparam int W1 = 32;
    localparam int D1 = 2;
    localparam int W2 = 13;
    localparam int D2 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          iv1, ir1, ov1, or1, cin1, sub1, co1, ovf1, z1;
    logic [W1-1:0] a1, b1, s1;
    logic          iv2, ir2, ov2, or2, cin2, sub2, co2, ovf2, z2;
    logic [W2-1:0] a2, b2, s2;

    prefix_adder_pipe #(.WIDTH(W1), .PIPE_DEPTH(D1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
        .cout(co1), .ovf(ovf1), .zero(z1));

    prefix_adder_pipe #(.WIDTH(W2), .PIPE_DEPTH(D2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(s2),
        .cout(co2), .ovf(ovf2), .zero(z2));

    int n_chk = 0;
    int n_err = 0;
    logic [66:0] q1[$];
    logic [66:0] q2[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Golden model: plain integer add, result packed as {sum, cout, ovf, zero}.
    function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] mask, bp, full, s;
        logic        co, cm, ov;
        mask = (64'd1 << w) - 64'd1;
        bp   = (sub ? ~b : b) & mask;
        full = (a & mask) + bp + {63'd0, (sub | cin)};
        s    = full & mask;
        co   = full[w];
        cm   = s[w-1] ^ a[w-1] ^ bp[w-1];
        ov   = cm ^ co;
`ifdef ADDER_SAT_EN
        if (ov) s = a[w-1] ? (64'd1 << (w - 1)) : (mask >> 1);
`endif
        return {s, co, ov, (s == 64'd0)};
    endfunction

    logic        stall1 = 1'b0;
    logic [66:0] held1;

    always @(negedge clk) begin
        logic [66:0] cur;
        int          occ;
        cur = {32'd0, s1, co1, ovf1, z1};
        if (!rst_n) begin
            q1.delete();
            stall1 = 1'b0;
        end else begin
            occ = q1.size();
            chk("in_ready1", ir1, !(occ == D1 && !or1));
            if (iv1 && ir1) q1.push_back(model(W1, 64'(a1), 64'(b1), cin1, sub1));
            if (stall1) chk("hold1", cur, held1);
            if (ov1 && or1) begin
                if (q1.size() == 0) chk("unexpected_out1", 1, 0);
                else chk("result1", cur, q1.pop_front());
            end
            stall1 = ov1 && !or1;
            held1  = cur;
        end
    end

    always @(negedge clk) begin
        logic [66:0] cur;
        int          occ;
        cur = {51'd0, s2, co2, ovf2, z2};
        if (!rst_n) begin
            q2.delete();
        end else begin
            occ = q2.size();
            chk("in_ready2", ir2, !(occ == D2 && !or2));
            if (iv2 && ir2) q2.push_back(model(W2, 64'(a2), 64'(b2), cin2, sub2));
            if (ov2 && or2) begin
                if (q2.size() == 0) chk("unexpected_out2", 1, 0);
                else chk("result2", cur, q2.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic c, input logic s);
        int t;
        a1 = a; b1 = b; cin1 = c; sub1 = s; iv1 = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ir1) break;
        end
        if (t == 50) chk("accept_timeout1", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic send2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c, input logic s);
        int t;
        a2 = a; b2 = b; cin2 = c; sub2 = s; iv2 = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ir2) break;
        end
        if (t == 50) chk("accept_timeout2", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic lat1(input string tag);
        int c;
        c = 0;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (ov1) break;
        end
        chk(tag, c, D1);
    endtask

    task automatic lat2(input string tag);
        int c;
        c = 0;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (ov2) break;
        end
        chk(tag, c, D2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        rst_n = 1'b0;
        iv1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; or1 = 1;
        iv2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0; or2 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid1", ov1, 0);
        chk("rst_sum1", s1, 0);
        chk("rst_flags1", {co1, ovf1, z1}, 3'b000);
        chk("rst_valid2", ov2, 0);
        chk("rst_sum2", s2, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send1(32'h0000_0001, 32'hFFFF_FFFF, 0, 0); iv1 = 0;
        lat1("t1_latency");
        chk("t1_sum", s1, 32'h0);
        chk("t1_flags", {co1, ovf1, z1}, 3'b101);
        @(posedge clk); #1;

        send1(32'h7FFF_FFFF, 32'h0000_0001, 0, 0); iv1 = 0;
        lat1("t2_latency");
`ifdef ADDER_SAT_EN
        chk("t2_sum", s1, 32'h7FFF_FFFF);
`else
        chk("t2_sum", s1, 32'h8000_0000);
`endif
        chk("t2_ovf_cout", {ovf1, co1}, 2'b10);
        @(posedge clk); #1;

        send1(32'd5, 32'd7, 0, 1); iv1 = 0;
        lat1("t3a_latency");
        chk("t3a_sum", s1, 32'hFFFF_FFFE);
        chk("t3a_cout_ovf", {co1, ovf1}, 2'b00);
        @(posedge clk); #1;

        send1(32'd7, 32'd5, 1, 1); iv1 = 0;
        lat1("t3b_latency");
        chk("t3b_sum", s1, 32'd2);
        chk("t3b_cout", co1, 1);
        @(posedge clk); #1;

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    send1($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                iv1 = 0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    or1 = 1'($urandom_range(0, 1));
                end
            end
        join
        or1 = 1'b1;
        for (int t = 0; t < 50 && q1.size() != 0; t++) @(negedge clk);
        chk("drain1", q1.size(), 0);
        @(posedge clk); #1;

        send1(32'h1234_5678, 32'h1111_1111, 0, 0);
        a1 = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        iv1 = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_flush_valid", ov1, 0);
        end
        @(posedge clk); #1;
        send1(32'h0000_00FF, 32'h0000_0001, 0, 0); iv1 = 0;
        lat1("post_rst_latency");
        chk("post_rst_sum", s1, 32'h0000_0100);
        @(posedge clk); #1;

        send2(13'h0FFF, 13'h0001, 0, 0); iv2 = 0;
        lat2("w13_latency");
        chk("w13_sum", s2, 13'h1000);
        chk("w13_ovf", ovf2, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 2000; i++) begin
            logic [W2-1:0] ra, rb;
            ra = 13'($urandom_range(0, 8191));
            rb = 13'($urandom_range(0, 8191));
            for (int m = 0; m < 4; m++) begin
                send2(ra, rb, m[0], m[1]);
            end
        end
        iv2 = 0;
        for (int t = 0; t < 50 && q2.size() != 0; t++) @(negedge clk);
        chk("drain2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
